// File: rtl/bsync_monitor.sv
// BSYNC pulse-train monitor: period/high-time measurement, 55..65 Hz mode
// classification, lock and loss-of-signal. HIGH_WIDTH is built only with BSYNC_MON_DUTY_EN.
//
// state | meaning
// IDLE  | no edge seen since reset or loss of signal
// ARMED | one rising edge seen, first period counting
// MEAS  | at least one period measured, PERIOD valid
module bsync_monitor #(
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 2000000,
  parameter int TOL     = 2000,
  // Nominal mode periods are round(CLK_HZ / (55 + mode)); the default gives 909091..769231.
  parameter int CLK_HZ  = 50000000
) (
  input  logic             IO_SYS_CLK,
  input  logic             IO_RESET_KEY,
  input  logic             IO_BSYNC_IN,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH_WIDTH,
  output logic [3:0]       MODE_DET,
  output logic             MEAS_STB,
  output logic             LOCK,
  output logic             LOS,
  output logic             LED_LOCK
);

  typedef enum logic [1:0] {IDLE, ARMED, MEAS} state_t;

  localparam logic [CNT_W-1:0]     TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic signed [CNT_W:0] TOL_C    = (CNT_W+1)'(TOL);

  function automatic logic [CNT_W-1:0] nominal(input int mode);
    int div;
    div = 55 + mode;
    return CNT_W'((CLK_HZ + div / 2) / div);
  endfunction

  state_t           state;
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] per_cnt;
  logic [3:0]       mode_next;
  logic signed [CNT_W:0] diff;
  logic             rise;

  assign rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge IO_SYS_CLK or negedge IO_RESET_KEY) begin
    if (!IO_RESET_KEY) sync_q <= '0;
    else               sync_q <= {sync_q[1:0], IO_BSYNC_IN};
  end

  // Signed, one bit wider than the counter so |period - nominal| never wraps.
  always_comb begin
    mode_next = 4'd15;
    diff      = '0;
    for (int m = 10; m >= 0; m--) begin
      diff = $signed({1'b0, per_cnt}) - $signed({1'b0, nominal(m)});
      if (diff <= TOL_C && diff >= -TOL_C) mode_next = 4'(m);
    end
  end

  always_ff @(posedge IO_SYS_CLK or negedge IO_RESET_KEY) begin
    if (!IO_RESET_KEY) begin
      state    <= IDLE;
      per_cnt  <= '0;
      PERIOD   <= '0;
      MODE_DET <= 4'd15;
      MEAS_STB <= 1'b0;
      LOCK     <= 1'b0;
      LOS      <= 1'b0;
      LED_LOCK <= 1'b0;
    end else begin
      MEAS_STB <= 1'b0;
      LED_LOCK <= LOCK;
      case (state)
        IDLE: begin
          if (rise) begin
            state   <= ARMED;
            per_cnt <= CNT_W'(1);
          end
        end
        default: begin
          // An edge arriving on the timeout cycle is still a valid measurement.
          if (rise) begin
            PERIOD   <= per_cnt;
            MODE_DET <= mode_next;
            MEAS_STB <= 1'b1;
            LOCK     <= (mode_next != 4'd15) && (mode_next == MODE_DET);
            LOS      <= 1'b0;
            per_cnt  <= CNT_W'(1);
            state    <= MEAS;
          end else if (per_cnt >= TIMEOUT_C) begin
            state    <= IDLE;
            LOS      <= 1'b1;
            LOCK     <= 1'b0;
            MODE_DET <= 4'd15;
          end else begin
            per_cnt <= per_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef BSYNC_MON_DUTY_EN
  logic [CNT_W-1:0] hi_cnt;
  logic             fall;

  assign fall = ~sync_q[1] & sync_q[2];

  always_ff @(posedge IO_SYS_CLK or negedge IO_RESET_KEY) begin
    if (!IO_RESET_KEY) begin
      hi_cnt     <= '0;
      HIGH_WIDTH <= '0;
    end else begin
      if (rise)                          hi_cnt <= CNT_W'(1);
      else if (sync_q[1] && hi_cnt != '1) hi_cnt <= hi_cnt + 1'b1;
      // Before the first rising edge hi_cnt holds nothing meaningful.
      if (fall && state != IDLE) HIGH_WIDTH <= hi_cnt;
    end
  end
`else
  assign HIGH_WIDTH = '0;
`endif

endmodule
